// File: rtl/load_store_unit.sv
// Load/store unit: takes one memory op at a time from execute, runs it on a
// request/grant data bus and returns load results or a one-cycle exception.
package lsu_pkg;
    localparam int cXLEN = 32;

    typedef struct packed {
        logic             read;
        logic             write;
        logic [cXLEN-1:0] addr;
        logic [cXLEN-1:0] data;
        logic [2:0]       opType;
        logic [4:0]       rdAddr;
    } tMemOp;

    typedef struct packed {
        logic             dv;
        logic [4:0]       addr;
        logic [cXLEN-1:0] data;
    } tRegOp;
endpackage

module load_store_unit
    import lsu_pkg::*;
#(
    parameter int cBusTimeout = 255
) (
    input  logic             clk,
    input  logic             rstn,
    input  tMemOp            memOpIn,
    input  logic             memOpDv,
    output logic             memOpRdy,
    output logic             dMemReq,
    output logic             dMemWe,
    output logic [cXLEN-1:0] dMemAddr,
    output logic [cXLEN-1:0] dMemWData,
    output logic [3:0]       dMemBe,
    input  logic             dMemGnt,
    input  logic             dMemRValid,
    input  logic [cXLEN-1:0] dMemRData,
    output tRegOp            regOpOut,
    output logic             excDv,
    output logic [1:0]       excCode,
    output logic [cXLEN-1:0] excAddr
);
    localparam int CNT_W = $clog2(cBusTimeout + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(cBusTimeout - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op_type;
    logic [cXLEN-1:0] op_addr;
    logic [4:0]       op_rd;
    logic             accept;
    logic             bad_op;
    logic             misaligned;
    logic             legal_go;

    function automatic logic is_illegal(input tMemOp op);
        if (op.read == op.write)
            return 1'b1;
        if (op.write)
            return !(op.opType inside {3'b000, 3'b001, 3'b010});
        return !(op.opType inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    endfunction

    function automatic logic is_misaligned(input tMemOp op);
        case (op.opType[1:0])
            2'b01:   return op.addr[0];
            2'b10:   return op.addr[1:0] != 2'b00;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [3:0] byte_en(input logic [2:0] t, input logic [1:0] a);
        case (t[1:0])
            2'b00:   return 4'b0001 << a;
            2'b01:   return 4'b0011 << {a[1], 1'b0};
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [cXLEN-1:0] store_data(input logic [2:0] t, input logic [cXLEN-1:0] d);
        case (t[1:0])
            2'b00:   return {4{d[7:0]}};
            2'b01:   return {2{d[15:0]}};
            default: return d;
        endcase
    endfunction

    function automatic logic [cXLEN-1:0] load_extract(input logic [2:0] t, input logic [1:0] a,
                                                      input logic [cXLEN-1:0] rdata);
        logic [cXLEN-1:0]  lane;
        logic signed [7:0]  lane_b;
        logic signed [15:0] lane_h;
        lane   = rdata >> {a, 3'b000};
        lane_b = lane[7:0];
        lane_h = lane[15:0];
        case (t)
            3'b000:  return cXLEN'(lane_b);
            3'b001:  return cXLEN'(lane_h);
            3'b100:  return {24'd0, lane[7:0]};
            3'b101:  return {16'd0, lane[15:0]};
            default: return lane;
        endcase
    endfunction

    assign memOpRdy   = (state == IDLE);
    assign accept     = memOpDv && memOpRdy;
    assign bad_op     = is_illegal(memOpIn);
    assign misaligned = is_misaligned(memOpIn);
    assign legal_go   = accept && !bad_op && !misaligned;

    // Captured op context; only meaningful while an op is outstanding.
    always_ff @(posedge clk) begin
        if (legal_go) begin
            op_type <= memOpIn.opType;
            op_addr <= memOpIn.addr;
            op_rd   <= memOpIn.rdAddr;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            dMemReq   <= 1'b0;
            dMemWe    <= 1'b0;
            dMemAddr  <= '0;
            dMemWData <= '0;
            dMemBe    <= '0;
            regOpOut  <= '0;
            excDv     <= 1'b0;
            excCode   <= 2'b00;
            excAddr   <= '0;
        end else begin
            excDv       <= 1'b0;
            regOpOut.dv <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept && bad_op) begin
                        excDv   <= 1'b1;
                        excCode <= 2'b10;
                        excAddr <= memOpIn.addr;
                    end else if (accept && misaligned) begin
                        excDv   <= 1'b1;
                        excCode <= 2'b01;
                        excAddr <= memOpIn.addr;
                    end else if (legal_go) begin
                        state     <= REQ;
                        cnt       <= '0;
                        dMemReq   <= 1'b1;
                        dMemWe    <= memOpIn.write;
                        dMemAddr  <= {memOpIn.addr[cXLEN-1:2], 2'b00};
                        dMemWData <= store_data(memOpIn.opType, memOpIn.data);
                        dMemBe    <= byte_en(memOpIn.opType, memOpIn.addr[1:0]);
                    end
                end
                REQ: begin
                    if (dMemGnt) begin
                        dMemReq <= 1'b0;
                        cnt     <= '0;
                        state   <= dMemWe ? IDLE : WAIT;
                    end else if (cnt == CNT_LAST) begin
                        dMemReq <= 1'b0;
                        excDv   <= 1'b1;
                        excCode <= 2'b11;
                        excAddr <= op_addr;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                WAIT: begin
                    if (dMemRValid) begin
                        // rd 0 still finishes the bus read but writes nothing back
                        regOpOut.dv   <= (op_rd != 5'd0);
                        regOpOut.addr <= op_rd;
                        regOpOut.data <= load_extract(op_type, op_addr[1:0], dMemRData);
                        state         <= RESP;
                    end else if (cnt == CNT_LAST) begin
                        excDv   <= 1'b1;
                        excCode <= 2'b11;
                        excAddr <= op_addr;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RESP:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
